// File: rtl/nx_msg_arb_pkg.sv
// Shared types for the node message arbiter: link directions and source indices.
// No logic; constants only.
// Used by nx_msg_arbiter and nx_msg_arb_port (stats build: NX_MSG_ARB_STATS_EN).
package nx_msg_arb_pkg;

  typedef enum logic [1:0] {
    DIRX_NORTH = 2'd0,
    DIRX_EAST  = 2'd1,
    DIRX_SOUTH = 2'd2,
    DIRX_WEST  = 2'd3
  } nx_dir_e;

  localparam int NUM_DIRS    = 4;
  localparam int ARB_SRC_INT = 0;
  localparam int ARB_SRC_BYP = 1;

endpackage

// File: rtl/nx_msg_arb_port.sv
// One link direction: 2-way round-robin grant into a registered output slot.
// Latency 1 cycle; grant is combinational on link_rdy so drain and refill share a cycle.
// Full slot with link_rdy low grants nobody. Saturating counters under NX_MSG_ARB_STATS_EN.
module nx_msg_arb_port
  import nx_msg_arb_pkg::*;
#(
  parameter int STREAM_WIDTH = 32
`ifdef NX_MSG_ARB_STATS_EN
  , parameter int STAT_WIDTH = 16
`endif
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [1:0]                 req_vld,
  input  logic [1:0][STREAM_WIDTH-1:0] req_dat,
  output logic [1:0]                 gnt,
  input  logic                       link_rdy,
  output logic                       link_vld,
  output logic [STREAM_WIDTH-1:0]    link_dat
`ifdef NX_MSG_ARB_STATS_EN
  , output logic [1:0][STAT_WIDTH-1:0] stat_cnt
`endif
);

  logic                    vld_q;
  logic [STREAM_WIDTH-1:0] dat_q;
  logic                    prio_byp_q;  // 1: bypass wins the next contended cycle
  logic                    slot_free;
  logic                    contended;

  assign slot_free = !vld_q || link_rdy;
  assign contended = &req_vld;
  assign link_vld  = vld_q;
  assign link_dat  = dat_q;

  always_comb begin
    gnt = '0;
    if (slot_free) begin
      if (contended) begin
        gnt[ARB_SRC_INT] = !prio_byp_q;
        gnt[ARB_SRC_BYP] = prio_byp_q;
      end else begin
        gnt = req_vld;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q      <= 1'b0;
      dat_q      <= '0;
      prio_byp_q <= 1'b0;
    end else begin
      if (gnt[ARB_SRC_INT]) begin
        dat_q <= req_dat[ARB_SRC_INT];
        vld_q <= 1'b1;
      end else if (gnt[ARB_SRC_BYP]) begin
        dat_q <= req_dat[ARB_SRC_BYP];
        vld_q <= 1'b1;
      end else if (link_rdy) begin
        vld_q <= 1'b0;
      end
      if (slot_free && contended) begin
        prio_byp_q <= !prio_byp_q;
      end
    end
  end

`ifdef NX_MSG_ARB_STATS_EN
  for (genvar s = 0; s < 2; s++) begin : g_stat
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        stat_cnt[s] <= '0;
      end else if (gnt[s] && (stat_cnt[s] != '1)) begin
        stat_cnt[s] <= stat_cnt[s] + 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/nx_msg_arbiter.sv
// Shares the four outbound links between the internal and bypass message sources.
// Latency 1 cycle; one message per direction per cycle, ready combinational on out_ready_i.
// Blocked direction stalls only its requester. Per-source accept stats under NX_MSG_ARB_STATS_EN.
module nx_msg_arbiter
  import nx_msg_arb_pkg::*;
#(
  parameter int STREAM_WIDTH = 32
`ifdef NX_MSG_ARB_STATS_EN
  , parameter int STAT_WIDTH = 16
`endif
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [STREAM_WIDTH-1:0]               int_data_i,
  input  logic [1:0]                            int_dir_i,
  input  logic                                  int_valid_i,
  output logic                                  int_ready_o,
  input  logic [STREAM_WIDTH-1:0]               byp_data_i,
  input  logic [1:0]                            byp_dir_i,
  input  logic                                  byp_valid_i,
  output logic                                  byp_ready_o,
  output logic [NUM_DIRS-1:0][STREAM_WIDTH-1:0] out_data_o,
  output logic [NUM_DIRS-1:0]                   out_valid_o,
  input  logic [NUM_DIRS-1:0]                   out_ready_i
`ifdef NX_MSG_ARB_STATS_EN
  , output logic [NUM_DIRS-1:0][STAT_WIDTH-1:0] stat_int_o
  , output logic [NUM_DIRS-1:0][STAT_WIDTH-1:0] stat_byp_o
`endif
);

  logic [NUM_DIRS-1:0] gnt_int;
  logic [NUM_DIRS-1:0] gnt_byp;

  for (genvar d = 0; d < NUM_DIRS; d++) begin : g_dir
    localparam nx_dir_e DIR = nx_dir_e'(2'(d));

    logic [1:0]                   req_vld;
    logic [1:0][STREAM_WIDTH-1:0] req_dat;
    logic [1:0]                   gnt;
`ifdef NX_MSG_ARB_STATS_EN
    logic [1:0][STAT_WIDTH-1:0]   stat_cnt;
`endif

    // Requests are masked in reset so neither source sees ready while the slots are held clear.
    assign req_vld[ARB_SRC_INT] = rst_ni && int_valid_i && (int_dir_i == DIR);
    assign req_vld[ARB_SRC_BYP] = rst_ni && byp_valid_i && (byp_dir_i == DIR);
    assign req_dat[ARB_SRC_INT] = int_data_i;
    assign req_dat[ARB_SRC_BYP] = byp_data_i;
    assign gnt_int[d]           = gnt[ARB_SRC_INT];
    assign gnt_byp[d]           = gnt[ARB_SRC_BYP];

    nx_msg_arb_port #(
      .STREAM_WIDTH (STREAM_WIDTH)
`ifdef NX_MSG_ARB_STATS_EN
      , .STAT_WIDTH (STAT_WIDTH)
`endif
    ) u_port (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .req_vld  (req_vld),
      .req_dat  (req_dat),
      .gnt      (gnt),
      .link_rdy (out_ready_i[d]),
      .link_vld (out_valid_o[d]),
      .link_dat (out_data_o[d])
`ifdef NX_MSG_ARB_STATS_EN
      , .stat_cnt (stat_cnt)
`endif
    );

`ifdef NX_MSG_ARB_STATS_EN
    assign stat_int_o[d] = stat_cnt[ARB_SRC_INT];
    assign stat_byp_o[d] = stat_cnt[ARB_SRC_BYP];
`endif
  end

  assign int_ready_o = gnt_int[int_dir_i];
  assign byp_ready_o = gnt_byp[byp_dir_i];

endmodule
